// File: rtl/id_stage_pipelined.sv
// Decode stage: field decode, register file with write bypass, RAW hazard
// detection against EX/MEM, and a stallable/flushable ID/EX register.
module id_stage_pipelined #(
  parameter int WORD_WIDTH = 32,
  parameter int REG_ADDR_W = 4,
  parameter int IMM_W      = 24,
  parameter int SHIFT_W    = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_WIDTH-1:0]   pc_in,
  input  logic [WORD_WIDTH-1:0]   instr_in,
  input  logic                    out_ready,
  input  logic                    flush,
  input  logic                    wb_en,
  input  logic [REG_ADDR_W-1:0]   wb_dest,
  input  logic [WORD_WIDTH-1:0]   wb_data,
  input  logic                    ex_wb_en,
  input  logic [REG_ADDR_W-1:0]   ex_dst,
  input  logic                    mem_wb_en,
  input  logic [REG_ADDR_W-1:0]   mem_dst,
  output logic                    hazard,
  output logic                    out_valid,
  output logic [WORD_WIDTH-1:0]   pc,
  output logic [WORD_WIDTH-1:0]   instr,
  output logic [3:0]              ex_cmd,
  output logic [REG_ADDR_W-1:0]   src1,
  output logic [REG_ADDR_W-1:0]   src2,
  output logic [REG_ADDR_W-1:0]   dst,
  output logic [WORD_WIDTH-1:0]   rn_val,
  output logic [WORD_WIDTH-1:0]   rm_val,
  output logic signed [IMM_W-1:0] simm,
  output logic [SHIFT_W-1:0]      shifter_op,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    wb_en_out,
  output logic                    imm,
  output logic                    b,
  output logic                    s_update
);
  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [WORD_WIDTH-1:0] regs [NUM_REGS];

  logic [1:0]            mode_p0;
  logic [3:0]            op_p0;
  logic [REG_ADDR_W-1:0] rn_p0, rd_p0, rm_p0, src2_p0;
  logic [3:0]            cmd_p0;
  logic                  valid_op_p0;
  logic                  mem_read_p0, mem_write_p0, wb_p0, imm_p0, b_p0, s_p0;
  logic                  use1_p0, use2_p0;
  logic [WORD_WIDTH-1:0] rn_val_p0, rm_val_p0;
  logic                  hz_ex_p0, hz_mem_p0, advance, accept;

  assign mode_p0 = instr_in[27:26];
  assign op_p0   = instr_in[24:21];
  assign rn_p0   = instr_in[16 +: REG_ADDR_W];
  assign rd_p0   = instr_in[12 +: REG_ADDR_W];
  assign rm_p0   = instr_in[0 +: REG_ADDR_W];

  always_comb begin
    cmd_p0       = 4'b0000;
    valid_op_p0  = 1'b0;
    mem_read_p0  = 1'b0;
    mem_write_p0 = 1'b0;
    wb_p0        = 1'b0;
    imm_p0       = 1'b0;
    b_p0         = 1'b0;
    s_p0         = 1'b0;
    use1_p0      = 1'b0;
    use2_p0      = 1'b0;
    case (mode_p0)
      2'b00: begin
        valid_op_p0 = 1'b1;
        case (op_p0)
          4'b1101: cmd_p0 = 4'b0001;
          4'b1111: cmd_p0 = 4'b1001;
          4'b0100: cmd_p0 = 4'b0010;
          4'b0101: cmd_p0 = 4'b0011;
          4'b0010: cmd_p0 = 4'b0100;
          4'b0110: cmd_p0 = 4'b0101;
          4'b0000: cmd_p0 = 4'b0110;
          4'b1100: cmd_p0 = 4'b0111;
          4'b0001: cmd_p0 = 4'b1000;
          4'b1010: cmd_p0 = 4'b0100;
          4'b1000: cmd_p0 = 4'b0110;
          default: valid_op_p0 = 1'b0;
        endcase
        if (valid_op_p0) begin
          // CMP/TST only set flags; MOV/MVN ignore Rn
          wb_p0   = (op_p0 != 4'b1010) && (op_p0 != 4'b1000);
          s_p0    = instr_in[20];
          imm_p0  = instr_in[25];
          use1_p0 = (op_p0 != 4'b1101) && (op_p0 != 4'b1111);
          use2_p0 = ~instr_in[25];
        end
      end
      2'b01: begin
        if (op_p0 == 4'b0100) begin
          cmd_p0  = 4'b0010;
          imm_p0  = instr_in[25];
          use1_p0 = 1'b1;
          if (instr_in[20]) begin
            mem_read_p0 = 1'b1;
            wb_p0       = 1'b1;
          end else begin
            mem_write_p0 = 1'b1;
            use2_p0      = 1'b1;
          end
        end
      end
      2'b10:   b_p0 = 1'b1;
      default: ;
    endcase
  end

  // STR reads its store data from the Rd field
  assign src2_p0 = mem_write_p0 ? rd_p0 : rm_p0;

  assign rn_val_p0 = (wb_en && (wb_dest == rn_p0))   ? wb_data : regs[rn_p0];
  assign rm_val_p0 = (wb_en && (wb_dest == src2_p0)) ? wb_data : regs[src2_p0];

  assign hz_ex_p0  = ex_wb_en  && ((use1_p0 && (rn_p0 == ex_dst))  || (use2_p0 && (src2_p0 == ex_dst)));
  assign hz_mem_p0 = mem_wb_en && ((use1_p0 && (rn_p0 == mem_dst)) || (use2_p0 && (src2_p0 == mem_dst)));
  assign hazard    = in_valid && (hz_ex_p0 || hz_mem_p0);

  assign advance  = out_ready || ~out_valid;
  assign in_ready = advance && ~hazard && ~flush;
  assign accept   = advance && in_valid && ~hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_dest] <= wb_data;
    end
  end

  // ---- ID/EX register boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      pc         <= '0;
      instr      <= '0;
      ex_cmd     <= '0;
      src1       <= '0;
      src2       <= '0;
      dst        <= '0;
      rn_val     <= '0;
      rm_val     <= '0;
      simm       <= '0;
      shifter_op <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      wb_en_out  <= 1'b0;
      imm        <= 1'b0;
      b          <= 1'b0;
      s_update   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      pc         <= pc_in;
      instr      <= instr_in;
      ex_cmd     <= cmd_p0;
      src1       <= rn_p0;
      src2       <= src2_p0;
      dst        <= rd_p0;
      rn_val     <= rn_val_p0;
      rm_val     <= rm_val_p0;
      simm       <= $signed(instr_in[IMM_W-1:0]);
      shifter_op <= instr_in[SHIFT_W-1:0];
      mem_read   <= mem_read_p0;
      mem_write  <= mem_write_p0;
      wb_en_out  <= wb_p0;
      imm        <= imm_p0;
      b          <= b_p0;
      s_update   <= s_p0;
    end else if (advance) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: directed instruction stream checked every
// cycle against a transaction-level model, plus hand-computed spot values.
module tb_id_stage_pipelined;
  localparam int WW = 32;
  localparam int RA = 4;
  localparam int IW = 24;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_ready, flush;
  logic [WW-1:0] pc_in, instr_in;
  logic          wb_en, ex_wb_en, mem_wb_en;
  logic [RA-1:0] wb_dest, ex_dst, mem_dst;
  logic [WW-1:0] wb_data;
  logic          hazard, out_valid;
  logic [WW-1:0] pc, instr, rn_val, rm_val;
  logic [3:0]    ex_cmd;
  logic [RA-1:0] src1, src2, dst;
  logic [IW-1:0] simm;
  logic [SW-1:0] shifter_op;
  logic          mem_read, mem_write, wb_en_out, imm, b, s_update;

  always #5 clk = ~clk;

  id_stage_pipelined #(.WORD_WIDTH(WW), .REG_ADDR_W(RA), .IMM_W(IW), .SHIFT_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instr_in(instr_in), .out_ready(out_ready), .flush(flush),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .ex_wb_en(ex_wb_en), .ex_dst(ex_dst), .mem_wb_en(mem_wb_en), .mem_dst(mem_dst),
    .hazard(hazard), .out_valid(out_valid), .pc(pc), .instr(instr), .ex_cmd(ex_cmd),
    .src1(src1), .src2(src2), .dst(dst), .rn_val(rn_val), .rm_val(rm_val),
    .simm(simm), .shifter_op(shifter_op), .mem_read(mem_read), .mem_write(mem_write),
    .wb_en_out(wb_en_out), .imm(imm), .b(b), .s_update(s_update)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // What an instruction means, straight from the decode table
  typedef struct packed {
    logic [3:0] cmd;
    logic mr, mw, wb, im, br, s, use1, use2;
  } dec_t;

  function automatic dec_t decode(input logic [WW-1:0] ins);
    dec_t d;
    logic [3:0] op;
    d  = '0;
    op = ins[24:21];
    if (ins[27:26] == 2'b00) begin
      case (op)
        4'b1101: d.cmd = 4'b0001;
        4'b1111: d.cmd = 4'b1001;
        4'b0100: d.cmd = 4'b0010;
        4'b0101: d.cmd = 4'b0011;
        4'b0010: d.cmd = 4'b0100;
        4'b0110: d.cmd = 4'b0101;
        4'b0000: d.cmd = 4'b0110;
        4'b1100: d.cmd = 4'b0111;
        4'b0001: d.cmd = 4'b1000;
        4'b1010: d.cmd = 4'b0100;
        4'b1000: d.cmd = 4'b0110;
        default: d.cmd = 4'b0000;
      endcase
      if (d.cmd != 4'b0000) begin
        d.wb   = !(op inside {4'b1010, 4'b1000});
        d.s    = ins[20];
        d.im   = ins[25];
        d.use1 = !(op inside {4'b1101, 4'b1111});
        d.use2 = !ins[25];
      end
    end else if (ins[27:26] == 2'b01 && op == 4'b0100) begin
      d.cmd  = 4'b0010;
      d.im   = ins[25];
      d.use1 = 1'b1;
      d.mr   = ins[20];
      d.wb   = ins[20];
      d.mw   = !ins[20];
      d.use2 = !ins[20];
    end else if (ins[27:26] == 2'b10) begin
      d.br = 1'b1;
    end
    return d;
  endfunction

  logic [WW-1:0] m_regs [16];
  logic          m_valid;
  logic [WW-1:0] m_pc, m_instr, m_rn, m_rm;

  function automatic logic [RA-1:0] src2_of(input logic [WW-1:0] ins);
    return decode(ins).mw ? ins[15:12] : ins[3:0];
  endfunction

  function automatic logic [WW-1:0] rd_reg(input logic [RA-1:0] a);
    return (wb_en && wb_dest == a) ? wb_data : m_regs[a];
  endfunction

  function automatic logic clash(input logic [RA-1:0] a);
    return (ex_wb_en && ex_dst == a) || (mem_wb_en && mem_dst == a);
  endfunction

  function automatic logic exp_hazard();
    dec_t d;
    d = decode(instr_in);
    return in_valid && ((d.use1 && clash(instr_in[19:16])) || (d.use2 && clash(src2_of(instr_in))));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_pc    <= '0;
      m_instr <= '0;
      m_rn    <= '0;
      m_rm    <= '0;
      for (int i = 0; i < 16; i++) m_regs[i] <= '0;
    end else begin
      if (wb_en) m_regs[wb_dest] <= wb_data;
      if (flush) m_valid <= 1'b0;
      else if ((out_ready || !m_valid) && in_valid && !exp_hazard()) begin
        m_valid <= 1'b1;
        m_pc    <= pc_in;
        m_instr <= instr_in;
        m_rn    <= rd_reg(instr_in[19:16]);
        m_rm    <= rd_reg(src2_of(instr_in));
      end else if (out_ready || !m_valid) m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    dec_t d;
    if (!rst) begin
      d = decode(m_instr);
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("hazard", 64'(hazard), 64'(exp_hazard()));
      chk("in_ready", 64'(in_ready), 64'((out_ready || !m_valid) && !exp_hazard() && !flush));
      if (m_valid) begin
        chk("pc", 64'(pc), 64'(m_pc));
        chk("instr", 64'(instr), 64'(m_instr));
        chk("ex_cmd", 64'(ex_cmd), 64'(d.cmd));
        chk("src1", 64'(src1), 64'(m_instr[19:16]));
        chk("src2", 64'(src2), 64'(src2_of(m_instr)));
        chk("dst", 64'(dst), 64'(m_instr[15:12]));
        chk("rn_val", 64'(rn_val), 64'(m_rn));
        chk("rm_val", 64'(rm_val), 64'(m_rm));
        chk("simm", 64'(simm), 64'(m_instr[IW-1:0]));
        chk("shifter_op", 64'(shifter_op), 64'(m_instr[SW-1:0]));
        chk("ctrl", 64'({mem_read, mem_write, wb_en_out, imm, b, s_update}),
            64'({d.mr, d.mw, d.wb, d.im, d.br, d.s}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [WW-1:0] p, input logic [WW-1:0] ins);
    in_valid = 1'b1;
    pc_in    = p;
    instr_in = ins;
  endtask

  localparam logic [WW-1:0] ADD_R1_R2_R3 = 32'hE0821003;
  localparam logic [WW-1:0] STR_R4_R5    = 32'hE4854000;

  logic [WW-1:0] tbl_ins [9];
  logic [3:0]    tbl_cmd [9];

  initial begin
    tbl_ins = '{32'hE4954000, 32'hE2521001, 32'hE1520003, 32'hEA000010, 32'hEF000000,
                32'hE0621003, 32'hE0221003, 32'hE3E01005, 32'hE1120003};
    tbl_cmd = '{4'b0010, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                4'b0000, 4'b1000, 4'b1001, 4'b0110};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    pc_in = '0; instr_in = '0; wb_en = 1'b0; wb_dest = '0; wb_data = '0;
    ex_wb_en = 1'b0; ex_dst = '0; mem_wb_en = 1'b0; mem_dst = '0;
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_ex_cmd", 64'(ex_cmd), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    rst = 1'b0;

    wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'd5; tick();
    wb_dest = 4'd3; wb_data = 32'd7; tick();
    wb_en = 1'b0;

    out_ready = 1'b1;
    present(32'h100, ADD_R1_R2_R3); tick();
    in_valid = 1'b0;
    chk("add_valid", 64'(out_valid), 64'h1);
    chk("add_cmd", 64'(ex_cmd), 64'h2);
    chk("add_rn", 64'(rn_val), 64'h5);
    chk("add_rm", 64'(rm_val), 64'h7);
    chk("add_wb", 64'(wb_en_out), 64'h1);

    ex_dst = 4'd2; ex_wb_en = 1'b1;
    present(32'h104, ADD_R1_R2_R3); #1;
    chk("ex_hazard", 64'(hazard), 64'h1);
    chk("ex_hazard_rdy", 64'(in_ready), 64'h0);
    tick();
    chk("bubble", 64'(out_valid), 64'h0);
    ex_wb_en = 1'b0; #1;
    chk("hazard_clear", 64'(hazard), 64'h0);
    tick();
    chk("after_hz_pc", 64'(pc), 64'h104);

    mem_dst = 4'd3; mem_wb_en = 1'b1;
    present(32'h108, ADD_R1_R2_R3); #1;
    chk("mem_hazard_rm", 64'(hazard), 64'h1);
    tick();
    mem_wb_en = 1'b0;

    ex_dst = 4'd0; ex_wb_en = 1'b1;
    present(32'h10C, 32'hE1A00003); #1;
    chk("mov_no_rn_use", 64'(hazard), 64'h0);
    tick();
    ex_wb_en = 1'b0;

    ex_dst = 4'd4; ex_wb_en = 1'b1;
    present(32'h110, STR_R4_R5); #1;
    chk("str_src2_hazard", 64'(hazard), 64'h1);
    tick();
    ex_wb_en = 1'b0;
    wb_en = 1'b1; wb_dest = 4'd4; wb_data = 32'hAA;
    tick();
    wb_en = 1'b0;
    chk("str_src2", 64'(src2), 64'h4);
    chk("str_rm", 64'(rm_val), 64'hAA);
    chk("str_mw", 64'(mem_write), 64'h1);

    for (int i = 0; i < 9; i++) begin
      present(32'h400 + 32'(4 * i), tbl_ins[i]);
      tick();
      chk("tbl_cmd", 64'(ex_cmd), 64'(tbl_cmd[i]));
    end
    chk("b_bit_after_tst", 64'(b), 64'h0);

    out_ready = 1'b0;
    present(32'h200, ADD_R1_R2_R3);
    repeat (3) begin
      tick();
      chk("stall_ready", 64'(in_ready), 64'h0);
      chk("stall_pc", 64'(pc), 64'h420);
    end
    out_ready = 1'b1;
    tick();
    chk("resume_pc", 64'(pc), 64'h200);

    present(32'h300, ADD_R1_R2_R3);
    flush = 1'b1; wb_en = 1'b1; wb_dest = 4'd6; wb_data = 32'h66;
    tick();
    flush = 1'b0; wb_en = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'h0);
    present(32'h304, 32'hE0861003);
    tick();
    chk("flush_wb_rn", 64'(rn_val), 64'h66);

    present(32'h308, ADD_R1_R2_R3);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_rn", 64'(rn_val), 64'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    present(32'h30C, ADD_R1_R2_R3);
    tick();
    chk("post_rst_rn", 64'(rn_val), 64'h0);
    chk("post_rst_rm", 64'(rm_val), 64'h0);
    in_valid = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
